mem_access_sequencer: RTL and testbench
=======================================

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req  in  1  access request; accepted when req & ready.
REQ-005 Port: we  in  1  1 = store, 0 = load.
REQ-006 Port: funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 Port: addr  in  ADDR_W  byte address.
REQ-008 Port: wdata  in  32  store data; byte/half taken from low bits.
REQ-009 Port: ready  out  1  sequencer idle, can accept.
REQ-010 Port: done  out  1  one-cycle completion pulse.
REQ-011 Port: rdata  out  32  extended load result; valid while done=1, held until the next load completes.
REQ-012 Port: err  out  1  one-cycle misalignment pulse; present only under MISALIGN_TRAP_EN.
REQ-013 Port: mem_addr  out  ADDR_W  word-aligned address; bits [1:0] always 0.
REQ-014 Port: mem_we  out  1  word write strobe.
REQ-015 Port: mem_wdata  out  32  word write data.
REQ-016 Port: mem_rdata  in  32  synchronous-read data, valid one cycle after mem_addr is presented.

Function
REQ-017 States: IDLE, RD, LD, WR, ERR; ready = (state==IDLE) & ~reset.
REQ-018 On acceptance the block registers we, funct3, addr, wdata; inputs need not be held afterwards.
REQ-019 req while ready=0 is ignored, with no queuing.
REQ-020 Transitions from IDLE:
- load -> RD
- word store -> WR
- byte/half store -> RD
REQ-021 RD drives mem_addr; next state is LD for a load, WR for a store.
REQ-022 LD: rdata registered from mem_rdata lane, done=1, next IDLE; total load latency 2 cycles after acceptance.
REQ-023 Lane select is little-endian:
- byte: addr[1:0]
- half: addr[1]
- B/H: sign-extend
- BU/HU: zero-extend
REQ-024 WR asserts mem_we=1 and done=1 for exactly one cycle, then IDLE.
- word store: mem_wdata = wdata, latency 1.
- sub-word store: mem_wdata = mem_rdata with the selected lane replaced, others unchanged; latency 2.
REQ-025 Codes 011, 110, 111, and 1xx on stores are executed as word accesses.
REQ-026 mem_we is 0 in every state except WR; done and err are never 1 together.
REQ-027 Back-to-back: a new req may be accepted in the cycle after done.

Reset
REQ-028 Reset state is IDLE, with:
- done=0, err=0, mem_we=0
- rdata=0, mem_addr=0, mem_wdata=0
REQ-029 Reset asserted mid-operation (RD, LD or WR) aborts the access in that cycle:
- no done
- no mem_we
- the pending write is lost.
REQ-030 After reset deasserts, ready=1.

Configuration
REQ-031 Macro MISALIGN_TRAP_EN, when defined, enables misalignment trapping.
- Misaligned accesses are half with addr[0]=1, or word with addr[1:0]!=0.
- Such an access goes IDLE -> ERR -> IDLE: err=1 for one cycle, no memory access, no done, rdata unchanged.
REQ-032 When MISALIGN_TRAP_EN is undefined:
- no err port and no ERR state.
- Misaligned accesses are forced aligned: half ignores addr[0], word ignores addr[1:0].

Verification
REQ-033 Memory word 0x40 = 0x8899AABB; LB addr 0x42 -> done at cycle 2, rdata = 0xFFFFFF99.
REQ-034 Same word; LHU addr 0x42 -> rdata = 0x00008899; LH addr 0x40 -> rdata = 0xFFFFAABB.
REQ-035 SB addr 0x41, wdata 0x123456CC -> RD then WR, mem_wdata = 0x8899CCBB, mem_we one cycle.
REQ-036 SW addr 0x40, wdata 0xDEADBEEF -> WR at cycle 1, mem_wdata = 0xDEADBEEF; req pulsed in WR is ignored.
REQ-037 SH addr 0x40 with reset asserted in WR -> mem_we=0 that cycle, no done, memory unchanged, ready=1 next cycle.
REQ-038 LW addr 0x42:
- with MISALIGN_TRAP_EN: err pulse, no mem access.
- without: reads 0x40, rdata = 0x8899AABB.

Source files
------------

// File: rtl/mem_access_sequencer_if.sv
// Request/response and word-memory signals of mem_access_sequencer.
// The err signal exists only when MISALIGN_TRAP_EN is defined.
interface mem_access_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic [31:0]       rdata;
`ifdef MISALIGN_TRAP_EN
    logic              err;
`endif
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rdata,
`ifdef MISALIGN_TRAP_EN
        output err,
`endif
        output ready, done, rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req, we, funct3, addr, wdata, mem_rdata,
`ifdef MISALIGN_TRAP_EN
        input  err,
`endif
        input  ready, done, rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// RV32I load/store sequencer over a word-wide synchronous-read memory.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses via err.
module mem_access_sequencer #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_access_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD,
        LD,
        WR
`ifdef MISALIGN_TRAP_EN
        , ERR
`endif
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              in_word;
`ifdef MISALIGN_TRAP_EN
    logic              in_misal;
`endif

    // Stores decode only 000/001 as sub-word; loads also 100/101.
    function automatic logic is_byte(input logic w, input logic [2:0] f);
        return w ? (f == 3'b000) : (f[1:0] == 2'b00);
    endfunction

    function automatic logic is_half(input logic w, input logic [2:0] f);
        return w ? (f == 3'b001) : (f[1:0] == 2'b01);
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f,
                                                 input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        if (f[1:0] == 2'b00) return {{24{b[7] & ~f[2]}}, b};
        if (f[1:0] == 2'b01) return {{16{h[15] & ~f[2]}}, h};
        return w;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [2:0] f, input logic [1:0] a);
        logic [31:0] r;
        r = w;
        if (f == 3'b000)      r[{a, 3'b000} +: 8]     = d[7:0];
        else if (f == 3'b001) r[{a[1], 4'b0000} +: 16] = d[15:0];
        else                  r = d;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        in_word = ~is_byte(bus.we, bus.funct3) & ~is_half(bus.we, bus.funct3);
`ifdef MISALIGN_TRAP_EN
        in_misal = is_half(bus.we, bus.funct3) ? bus.addr[0]
                                               : (in_word & (bus.addr[1:0] != 2'b00));
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    f3_d    = bus.funct3;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    state_d = (bus.we && in_word) ? WR : RD;
`ifdef MISALIGN_TRAP_EN
                    if (in_misal) state_d = ERR;
`endif
                end
            end
            RD: state_d = we_q ? WR : LD;
            LD: begin
                rdata_d = load_extract(bus.mem_rdata, f3_q, addr_q[1:0]);
                state_d = IDLE;
            end
            WR: state_d = IDLE;
`ifdef MISALIGN_TRAP_EN
            ERR: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by reset so an aborted access never strobes or completes.
    always_comb begin
        bus.ready     = (state_q == IDLE) && !reset;
        bus.done      = ((state_q == LD) || (state_q == WR)) && !reset;
        bus.mem_we    = (state_q == WR) && !reset;
        bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus.mem_wdata = '0;
        if ((state_q == WR) && !reset)
            bus.mem_wdata = store_merge(bus.mem_rdata, wdata_q, f3_q, addr_q[1:0]);
        bus.rdata = rdata_q;
        if ((state_q == LD) && !reset)
            bus.rdata = load_extract(bus.mem_rdata, f3_q, addr_q[1:0]);
`ifdef MISALIGN_TRAP_EN
        bus.err = (state_q == ERR) && !reset;
`endif
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed vector table,
// hand-written reset/ignore sequences and randomized accesses vs a byte-level model.
module tb_mem_access_sequencer;
    localparam int unsigned AW = 32;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic init_mem;
    logic err_sig;
    always #5 clk = ~clk;

    mem_access_sequencer_if #(.ADDR_W(AW)) bus();
    mem_access_sequencer #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef MISALIGN_TRAP_EN
    assign err_sig = bus.err;
`else
    assign err_sig = 1'b0;
`endif

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h8899AABB;
        if (i == 19) return 32'h11223344;
        return 32'h5A000000 ^ (32'(i) * 32'h00010203);
    endfunction

    // Word memory with one-cycle synchronous read.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end

    int we_pulses = 0;
    int both_hits = 0;
    always @(negedge clk) begin
        if (bus.mem_we) we_pulses++;
        if (bus.done && err_sig) both_hits++;
    end

    int checks = 0;
    int errors = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte-level arithmetic on a shadow memory image.
    logic [31:0] ref_mem [64];
    logic [31:0] ref_rdata;

    function automatic int size_of(input logic w, input logic [2:0] f);
        if (f == 3'b000) return 1;
        if (f == 3'b001) return 2;
        if (!w && f == 3'b100) return 1;
        if (!w && f == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] lane_mask(input int nb);
        return (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (nb * 8)) - 32'd1);
    endfunction

    function automatic int lane_off(input int nb, input logic [31:0] a);
        return (int'(a[1:0]) / nb) * nb * 8;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int nb, input bit sgn,
                                             input logic [31:0] a);
        logic [31:0] m, v;
        m = lane_mask(nb);
        v = (w >> lane_off(nb, a)) & m;
        if (sgn && nb < 4 && v[nb * 8 - 1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                              input int nb, input logic [31:0] a);
        logic [31:0] m;
        int off;
        m = lane_mask(nb);
        off = lane_off(nb, a);
        return (w & ~(m << off)) | ((d & m) << off);
    endfunction

    function automatic bit misaligned(input int nb, input logic [31:0] a);
        if (nb == 2) return a[0];
        if (nb == 4) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    task automatic run_access(input string tag, input logic w, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] d, input bit exp_err,
                              input int exp_lat, input logic [31:0] exp_rd,
                              input logic [31:0] exp_word);
        int lat, we0, idx;
        bit seen_err;
        logic [31:0] rd_at_done, held;
        idx = int'(a[7:2]);
        lat = 0;
        seen_err = 1'b0;
        rd_at_done = '0;
        check({tag, " ready-before"}, 32'(bus.ready), 32'd1);
        bus.req = 1'b1; bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d;
        we0 = we_pulses;
        @(posedge clk); #1;
        for (int c = 1; c <= 6; c++) begin
            if (bus.done || err_sig) begin
                lat = c;
                seen_err = err_sig;
                rd_at_done = bus.rdata;
                break;
            end
            // Garbage on the inputs while busy: must be ignored and not needed.
            bus.req = 1'($urandom); bus.we = 1'($urandom); bus.funct3 = 3'($urandom);
            bus.addr = {24'h0, 8'($urandom)}; bus.wdata = $urandom;
            @(posedge clk); #1;
        end
        bus.req = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(seen_err), 32'(exp_err));
        if (!w && !exp_err) check({tag, " rdata"}, rd_at_done, exp_rd);
        @(posedge clk); #1;
        held = (w || exp_err) ? ref_rdata : exp_rd;
        check({tag, " ready-after"}, 32'(bus.ready), 32'd1);
        check({tag, " done-pulse"}, 32'(bus.done | err_sig), 32'd0);
        check({tag, " rdata-held"}, bus.rdata, held);
        check({tag, " we-pulses"}, 32'(we_pulses - we0), 32'(w && !exp_err));
        check({tag, " mem-word"}, mem[idx], exp_word);
        ref_mem[idx] = exp_word;
        ref_rdata = held;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] d;
        bit          misal;
        int          lat;
        logic [31:0] rd;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    initial begin
        vec_t v;
        logic w;
        logic [2:0] f;
        logic [31:0] a, d, exp_rd, exp_word;
        int nb, idx, lat, w0;
        bit e;

        tbl[0]  = '{1'b0, 3'b000, 32'h42, 32'h0,        1'b0, 2, 32'hFFFFFF99, 32'h8899AABB};
        tbl[1]  = '{1'b0, 3'b101, 32'h42, 32'h0,        1'b0, 2, 32'h00008899, 32'h8899AABB};
        tbl[2]  = '{1'b0, 3'b001, 32'h40, 32'h0,        1'b0, 2, 32'hFFFFAABB, 32'h8899AABB};
        tbl[3]  = '{1'b0, 3'b100, 32'h43, 32'h0,        1'b0, 2, 32'h00000088, 32'h8899AABB};
        tbl[4]  = '{1'b0, 3'b010, 32'h40, 32'h0,        1'b0, 2, 32'h8899AABB, 32'h8899AABB};
        tbl[5]  = '{1'b0, 3'b010, 32'h42, 32'h0,        1'b1, 2, 32'h8899AABB, 32'h8899AABB};
        tbl[6]  = '{1'b0, 3'b001, 32'h41, 32'h0,        1'b1, 2, 32'hFFFFAABB, 32'h8899AABB};
        tbl[7]  = '{1'b1, 3'b000, 32'h41, 32'h123456CC, 1'b0, 2, 32'h0,        32'h8899CCBB};
        tbl[8]  = '{1'b1, 3'b001, 32'h42, 32'h00007777, 1'b0, 2, 32'h0,        32'h7777CCBB};
        tbl[9]  = '{1'b0, 3'b011, 32'h40, 32'h0,        1'b0, 2, 32'h7777CCBB, 32'h7777CCBB};
        tbl[10] = '{1'b0, 3'b000, 32'h41, 32'h0,        1'b0, 2, 32'hFFFFFFCC, 32'h7777CCBB};
        tbl[11] = '{1'b1, 3'b110, 32'h44, 32'h01020304, 1'b0, 1, 32'h0,        32'h01020304};
        tbl[12] = '{1'b1, 3'b100, 32'h48, 32'hA5A5A5A5, 1'b0, 1, 32'h0,        32'hA5A5A5A5};
        tbl[13] = '{1'b1, 3'b001, 32'h4D, 32'h0000BEEF, 1'b1, 2, 32'h0,        32'h1122BEEF};
        tbl[14] = '{1'b0, 3'b100, 32'h4F, 32'h0,        1'b0, 2, 32'h00000011, 32'h0};
        tbl[15] = '{1'b1, 3'b010, 32'h4A, 32'hCAFEF00D, 1'b1, 1, 32'h0,        32'hCAFEF00D};

        init_mem = 1'b1;
        reset = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        ref_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        reset = 1'b0;
        #1;
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset err", 32'(err_sig), 32'd0);
        check("reset mem_we", 32'(bus.mem_we), 32'd0);
        check("reset rdata", bus.rdata, 32'd0);
        check("reset mem_addr", bus.mem_addr, 32'd0);
        check("reset mem_wdata", bus.mem_wdata, 32'd0);

        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            idx = int'(v.a[7:2]);
            e = TRAP && v.misal;
            // Word at 0x4C depends on whether the misaligned SH at 0x4D was trapped.
            exp_word = e ? ref_mem[idx] : ((i == 14) ? ref_mem[idx] : v.word);
            run_access($sformatf("vec%0d", i), v.w, v.f, v.a, v.d, e, e ? 1 : v.lat,
                       v.rd, exp_word);
        end

        // Word store; a req pulsed during WR must be dropped.
        check("sw ready", 32'(bus.ready), 32'd1);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h40;
        bus.wdata = 32'hDEADBEEF;
        w0 = we_pulses;
        @(posedge clk); #1;
        check("sw done c1", 32'(bus.done), 32'd1);
        check("sw mem_we c1", 32'(bus.mem_we), 32'd1);
        check("sw mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check("sw mem_addr", bus.mem_addr, 32'h40);
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = 32'h80;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("sw req-in-WR ignored", 32'(bus.ready), 32'd1);
        check("sw done once", 32'(bus.done), 32'd0);
        check("sw mem", mem[16], 32'hDEADBEEF);
        check("sw we pulses", 32'(we_pulses - w0), 32'd1);
        ref_mem[16] = 32'hDEADBEEF;

        // Sub-word store aborted by reset in WR.
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b001; bus.addr = 32'h40;
        bus.wdata = 32'h00005555;
        w0 = we_pulses;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("sh rd no done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("sh reset mem_we", 32'(bus.mem_we), 32'd0);
        check("sh reset done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("sh reset ready", 32'(bus.ready), 32'd1);
        check("sh reset mem", mem[16], 32'hDEADBEEF);
        check("sh reset we pulses", 32'(we_pulses - w0), 32'd0);
        check("sh reset rdata", bus.rdata, 32'd0);
        ref_rdata = '0;
        @(posedge clk); #1;

        for (int n = 0; n < 200; n++) begin
            w = 1'($urandom);
            f = 3'($urandom);
            a = {24'h0, 8'($urandom)};
            d = $urandom;
            nb = size_of(w, f);
            idx = int'(a[7:2]);
            e = TRAP && misaligned(nb, a);
            if (w) begin
                exp_word = ref_store(ref_mem[idx], d, nb, a);
                exp_rd = ref_rdata;
                lat = (nb == 4) ? 1 : 2;
            end else begin
                exp_word = ref_mem[idx];
                exp_rd = ref_load(ref_mem[idx], nb, (f == 3'b000) || (f == 3'b001), a);
                lat = 2;
            end
            if (e) begin
                exp_word = ref_mem[idx];
                exp_rd = ref_rdata;
                lat = 1;
            end
            run_access($sformatf("rnd%0d", n), w, f, a, d, e, lat, exp_rd, exp_word);
        end

        check("done&err never together", 32'(both_hits), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
